// File: rtl/sobel_line_buffer.sv
// Line buffer feeding the Sobel convolver: turns a raster pixel stream into
// vertically aligned column vectors of M_DEPTH rows (current row at index 0).
module sobel_line_buffer #(
   parameter int COLORDEPTH = 8,
   parameter int M_DEPTH    = 3,
   parameter int LINE_MAX   = 2048,
   parameter int ADDR_W     = $clog2(LINE_MAX)
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [COLORDEPTH-1:0]                px_i,
   input  logic                                 dv_i,
   input  logic                                 hs_i,
   input  logic                                 vs_i,
   output logic [M_DEPTH-1:0][COLORDEPTH-1:0]   vect_o,
   output logic                                 dv_o,
   output logic                                 hs_o,
   output logic                                 vs_o,
   output logic                                 ovf_o
);

   localparam int NMEM = M_DEPTH - 1;
   localparam int LF_W = $clog2(M_DEPTH);
   localparam logic [ADDR_W-1:0] COL_MAX = ADDR_W'(LINE_MAX - 1);
   localparam logic [LF_W-1:0]   LF_MAX  = LF_W'(M_DEPTH - 1);

   logic                  dv_q;
   logic                  vs_q;
   logic [ADDR_W-1:0]     col;
   logic [ADDR_W-1:0]     col_n;
   logic [LF_W-1:0]       lf;
   logic [LF_W-1:0]       lf_n;
   logic                  full;
   logic                  full_n;
   logic                  ovf_n;
   logic                  we_q;
   logic [ADDR_W-1:0]     addr_q;
   logic [COLORDEPTH-1:0] px_q;

   logic                  vs_rise;
   logic                  dv_fall;
   logic [ADDR_W-1:0]     addr;
   logic [LF_W-1:0]       lf_eff;
   logic                  full_eff;

   logic [COLORDEPTH-1:0] rd_all [NMEM];

   // A frame start in the same cycle as a pixel clears first, so the pixel
   // lands at column 0 of an empty frame.
   always_comb begin
      vs_rise  = vs_i & ~vs_q;
      dv_fall  = dv_q & ~dv_i;
      addr     = vs_rise ? '0 : col;
      lf_eff   = vs_rise ? '0 : lf;
      full_eff = full & ~vs_rise;

      col_n = col;
      if (vs_rise)
         col_n = dv_i ? ADDR_W'(1) : '0;
      else if (dv_fall)
         col_n = '0;
      else if (dv_i && col != COL_MAX)
         col_n = col + ADDR_W'(1);

      full_n = full;
      if (vs_rise || dv_fall)
         full_n = 1'b0;
      else if (dv_i && col == COL_MAX)
         full_n = 1'b1;

      lf_n = lf;
      if (vs_rise)
         lf_n = '0;
      else if (dv_fall && lf != LF_MAX)
         lf_n = lf + LF_W'(1);

      ovf_n = ovf_o;
      if (vs_rise)
         ovf_n = 1'b0;
      else if (dv_i && full_eff)
         ovf_n = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dv_q   <= 1'b0;
         vs_q   <= 1'b0;
         col    <= '0;
         lf     <= '0;
         full   <= 1'b0;
         ovf_o  <= 1'b0;
         we_q   <= 1'b0;
         addr_q <= '0;
         px_q   <= '0;
         dv_o   <= 1'b0;
         hs_o   <= 1'b0;
         vs_o   <= 1'b0;
      end else begin
         dv_q   <= dv_i;
         vs_q   <= vs_i;
         col    <= col_n;
         lf     <= lf_n;
         full   <= full_n;
         ovf_o  <= ovf_n;
         we_q   <= dv_i & ~full_eff;
         addr_q <= addr;
         dv_o   <= dv_i;
         hs_o   <= hs_i;
         vs_o   <= vs_i;
         if (dv_i)
            px_q <= px_i;
      end
   end

   assign vect_o[0] = px_q;

   for (genvar j = 0; j < NMEM; j++) begin : g_mem
      logic [COLORDEPTH-1:0] mem [LINE_MAX];
      logic [COLORDEPTH-1:0] rd;
      logic [COLORDEPTH-1:0] wdat;
      logic                  vld;

      if (j == 0) begin : g_head
         assign wdat = px_q;
      end else begin : g_chain
         assign wdat = rd_all[j-1];
      end

      assign rd_all[j] = rd;

      always_ff @(posedge clk) begin
         if (we_q)
            mem[addr_q] <= wdat;
         if (dv_i)
            rd <= mem[addr];
      end

      // Rows not yet filled in this frame read as zero.
      always_ff @(posedge clk or posedge rst) begin
         if (rst)
            vld <= 1'b0;
         else if (dv_i)
            vld <= (lf_eff >= LF_W'(j + 1));
      end

      assign vect_o[j+1] = vld ? rd : '0;
   end

endmodule

// File: tb/tb_sobel_line_buffer.sv
// Directed bench for sobel_line_buffer: default build plus a LINE_MAX=8
// build sharing the same input stream for the overflow scenario.
module tb_sobel_line_buffer;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [7:0]      px_i = '0;
   logic            dv_i = 1'b0;
   logic            hs_i = 1'b0;
   logic            vs_i = 1'b0;

   logic [2:0][7:0] vect;
   logic            dv_o, hs_o, vs_o, ovf_o;
   logic [2:0][7:0] vect8;
   logic            dv8, hs8, vs8, ovf8;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   sobel_line_buffer dut (
      .clk(clk), .rst(rst), .px_i(px_i), .dv_i(dv_i),
      .hs_i(hs_i), .vs_i(vs_i), .vect_o(vect), .dv_o(dv_o),
      .hs_o(hs_o), .vs_o(vs_o), .ovf_o(ovf_o)
   );

   sobel_line_buffer #(.LINE_MAX(8)) dut8 (
      .clk(clk), .rst(rst), .px_i(px_i), .dv_i(dv_i),
      .hs_i(hs_i), .vs_i(vs_i), .vect_o(vect8), .dv_o(dv8),
      .hs_o(hs8), .vs_o(vs8), .ovf_o(ovf8)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic dv, input logic [7:0] px);
      dv_i = dv;
      px_i = px;
      tick();
   endtask

   task automatic gap(input int n);
      dv_i = 1'b0;
      repeat (n) tick();
   endtask

   task automatic vs_pulse();
      dv_i = 1'b0;
      vs_i = 1'b1;
      tick();
      vs_i = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) tick();
      n_chk++;
      if (vect !== 24'h0 || vect8 !== 24'h0) begin
         n_fail++;
         $display("FAIL reset_vect: got %h/%h want 0", vect, vect8);
      end
      n_chk++;
      if ({dv_o, hs_o, vs_o, ovf_o, ovf8} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_flags: got %b want 00000",
                  {dv_o, hs_o, vs_o, ovf_o, ovf8});
      end
      #2 rst = 1'b0;
      tick();
   endtask

   task automatic test_fill();
      logic [23:0] exp;
      logic [7:0]  v1, v2;
      vs_pulse();
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 4; c++) begin
            drive(1'b1, 8'(16*r + c));
            v1  = (r >= 1) ? 8'(16*(r-1) + c) : 8'h00;
            v2  = (r >= 2) ? 8'(16*(r-2) + c) : 8'h00;
            exp = {v2, v1, 8'(16*r + c)};
            n_chk++;
            if (vect !== exp) begin
               n_fail++;
               $display("FAIL fill_r%0d_c%0d: got %h want %h", r, c, vect, exp);
            end
            if (c == 0) begin
               n_chk++;
               if (dv_o !== 1'b1) begin
                  n_fail++;
                  $display("FAIL fill_dv_rise: got %b want 1", dv_o);
               end
            end
         end
         gap(2);
         n_chk++;
         if (dv_o !== 1'b0 || vect !== exp) begin
            n_fail++;
            $display("FAIL fill_gap_hold: got dv=%b %h want dv=0 %h",
                     dv_o, vect, exp);
         end
      end
   endtask

   task automatic test_steady();
      logic [23:0] exp;
      for (int c = 0; c < 4; c++) begin
         drive(1'b1, 8'(48 + c));
         exp = {8'(16 + c), 8'(32 + c), 8'(48 + c)};
         n_chk++;
         if (vect !== exp) begin
            n_fail++;
            $display("FAIL steady_c%0d: got %h want %h", c, vect, exp);
         end
      end
      gap(2);
   endtask

   task automatic test_frame_restart();
      logic [23:0] exp;
      vs_pulse();
      for (int c = 0; c < 4; c++) begin
         drive(1'b1, 8'(8'hA0 + c));
         exp = {16'h0, 8'(8'hA0 + c)};
         n_chk++;
         if (vect !== exp) begin
            n_fail++;
            $display("FAIL restart_c%0d: got %h want %h", c, vect, exp);
         end
      end
      gap(2);
   endtask

   task automatic test_sync_align();
      hs_i = 1'b1;
      #1;
      n_chk++;
      if (hs_o !== 1'b0) begin
         n_fail++;
         $display("FAIL sync_hs_early: got %b want 0", hs_o);
      end
      tick();
      n_chk++;
      if (hs_o !== 1'b1 || vs_o !== 1'b0 || vect !== 24'h0000A3) begin
         n_fail++;
         $display("FAIL sync_hs: got hs=%b vs=%b %h want 1 0 0000a3",
                  hs_o, vs_o, vect);
      end
      hs_i = 1'b0;
      vs_i = 1'b1;
      tick();
      n_chk++;
      if (hs_o !== 1'b0 || vs_o !== 1'b1 || vect !== 24'h0000A3) begin
         n_fail++;
         $display("FAIL sync_vs: got hs=%b vs=%b %h want 0 1 0000a3",
                  hs_o, vs_o, vect);
      end
      vs_i = 1'b0;
      tick();
      n_chk++;
      if (vs_o !== 1'b0 || dv_o !== 1'b0) begin
         n_fail++;
         $display("FAIL sync_vs_fall: got vs=%b dv=%b want 0 0", vs_o, dv_o);
      end
   endtask

   task automatic test_overflow();
      logic [23:0] exp;
      vs_pulse();
      for (int c = 0; c < 10; c++) begin
         drive(1'b1, 8'(8'h40 + c));
         n_chk++;
         if (ovf8 !== (c >= 8) || vect8[0] !== 8'(8'h40 + c)) begin
            n_fail++;
            $display("FAIL ovf_c%0d: got ovf=%b px=%h want ovf=%b px=%h",
                     c, ovf8, vect8[0], (c >= 8), 8'(8'h40 + c));
         end
      end
      n_chk++;
      if (ovf_o !== 1'b0) begin
         n_fail++;
         $display("FAIL ovf_big_line: got %b want 0", ovf_o);
      end
      gap(2);
      for (int c = 0; c < 8; c++) begin
         drive(1'b1, 8'(8'h60 + c));
         exp = {8'h00, 8'(8'h40 + c), 8'(8'h60 + c)};
         n_chk++;
         if (vect8 !== exp || ovf8 !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_next_c%0d: got %h ovf=%b want %h ovf=1",
                     c, vect8, ovf8, exp);
         end
      end
      gap(2);
      vs_i = 1'b1;
      #1;
      n_chk++;
      if (ovf8 !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf_hold: got %b want 1", ovf8);
      end
      tick();
      vs_i = 1'b0;
      n_chk++;
      if (ovf8 !== 1'b0) begin
         n_fail++;
         $display("FAIL ovf_clear: got %b want 0", ovf8);
      end
      tick();
   endtask

   task automatic test_async_reset();
      logic [23:0] exp;
      vs_pulse();
      for (int c = 0; c < 4; c++) drive(1'b1, 8'(8'h20 + c));
      gap(2);
      for (int c = 0; c < 4; c++) drive(1'b1, 8'(8'h30 + c));
      gap(2);
      drive(1'b1, 8'h50);
      drive(1'b1, 8'h51);
      n_chk++;
      if (vect !== 24'h213151) begin
         n_fail++;
         $display("FAIL arst_pre: got %h want 213151", vect);
      end
      #2 rst = 1'b1;
      #1;
      n_chk++;
      if (vect !== 24'h0 || {dv_o, hs_o, vs_o, ovf_o} !== 4'b0) begin
         n_fail++;
         $display("FAIL arst_immediate: got %h flags=%b want 0 0000",
                  vect, {dv_o, hs_o, vs_o, ovf_o});
      end
      dv_i = 1'b0;
      @(posedge clk);
      #3 rst = 1'b0;
      tick();
      for (int c = 0; c < 4; c++) begin
         drive(1'b1, 8'(8'h70 + c));
         exp = {16'h0, 8'(8'h70 + c)};
         n_chk++;
         if (vect !== exp) begin
            n_fail++;
            $display("FAIL arst_line0_c%0d: got %h want %h", c, vect, exp);
         end
      end
      gap(2);
      for (int c = 0; c < 4; c++) begin
         drive(1'b1, 8'(8'h78 + c));
         exp = {8'h00, 8'(8'h70 + c), 8'(8'h78 + c)};
         n_chk++;
         if (vect !== exp) begin
            n_fail++;
            $display("FAIL arst_line1_c%0d: got %h want %h", c, vect, exp);
         end
      end
      gap(2);
   endtask

   initial begin
      test_reset();
      test_fill();
      test_steady();
      test_frame_restart();
      test_sync_align();
      test_overflow();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/sobel_line_buffer.md
# sobel_line_buffer

Upstream feeder for the Sobel convolution stage: turns a raster pixel stream (one pixel per valid clock) into a column vector of `M_DEPTH` vertically aligned pixels, the current row and the previous `M_DEPTH-1` rows at the same column. It holds `M_DEPTH-1` line memories. Its registered outputs connect directly to the convolver's `vect_in`/`dv_i`/`hs_i`/`vs_i`.

## Interface
- `COLORDEPTH`, 8: bits per pixel.
- `M_DEPTH`, 3: rows per output vector. `M_DEPTH-1` line memories are instantiated.
- `LINE_MAX`, 2048: maximum pixels per line, which sets the memory depth.
- `ADDR_W`, `$clog2(LINE_MAX)`: column address width.

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `px_i`  in  COLORDEPTH  input pixel, sampled when `dv_i`=1.
- `dv_i`  in  1  pixel valid.
- `hs_i`  in  1  horizontal sync, passed through.
- `vs_i`  in  1  vertical sync. Its rising edge marks frame start.
- `vect_o[M_DEPTH-1:0]`  out  COLORDEPTH each  column vector:
  - `[0]` is the current row.
  - `[k]` is the row k lines above.
- `dv_o`, `hs_o`, `vs_o`  out  1 each  sync signals delayed to align with `vect_o`.
- `ovf_o`  out  1  sticky line-overflow flag.

## Operation
- Column counter `col` (ADDR_W bits):
  - Increments on every cycle with `dv_i`=1.
  - Clears on the `dv_i` falling edge (line end) and on the `vs_i` rising edge.
- Overflow:
  - When `col` = `LINE_MAX-1` and `dv_i`=1, `col` holds and no memory write occurs for later pixels of that line.
  - `ovf_o` sets and stays set until the next `vs_i` rising edge or `rst`.
- Memory access, for a pixel accepted at cycle t with address c:
  - At t, every line memory `mem[j]` (j = 0..M_DEPTH-2) performs a synchronous read at address c.
  - At t+1, `mem[0]` is written with the cycle-delayed `px_i`, and `mem[j]` (j ≥ 1) is written with the value read from `mem[j-1]`.
  - Both writes use the 1-cycle-delayed address c.
  - A read never coincides with a write to the same address, so the memory read/write mode is irrelevant.
- Output data:
  - `vect_o[0]` is `px_i` delayed by 1 cycle.
  - `vect_o[k]` (k ≥ 1) is the `mem[k-1]` read data.
- Fill counter `lines_filled` (0..M_DEPTH-1):
  - Increments on each line end, saturating at M_DEPTH-1.
  - Clears on the `vs_i` rising edge.
  - `vect_o[k]` is forced to 0 while k > `lines_filled`. Stale memory contents from a previous frame or from before reset are therefore never exposed.
- Output registers hold their last value while `dv_o`=0. Downstream qualifies data only with `dv_o`.
- Input constraint: lines are separated by at least 1 cycle with `dv_i`=0. Line length may vary between lines. Unwritten columns of a shorter previous line return whatever is in memory; this is not masked.

## Timing
- Latency from input to output for data, `dv_o`, `hs_o` and `vs_o` is exactly 1 clock. Sync signals are plain 1-stage delays.
- Throughput is 1 pixel per clock with no backpressure.
- Edge detection on `dv_i` and `vs_i` uses registered previous values. A `vs_i` rising edge and `dv_i`=1 in the same cycle:
  - Clear is applied first.
  - The pixel is written at column 0 with `lines_filled`=0.
- A line end coincident with a `vs_i` rising edge: the `vs_i` clear wins.
- Reset value of every output and internal register is 0: `vect_o` all 0, `dv_o`=`hs_o`=`vs_o`=0, `ovf_o`=0, `col`=0, `lines_filled`=0.
- Memory arrays are not reset. Masking through `lines_filled`=0 covers stale contents.
- Reset asserted mid-line drops the line. After release, the buffer restarts as for a new frame, even without a `vs_i` edge.

## Test plan
- Fill sequence:
  - Stimulus: frame start, then 3 lines of 4 pixels, line r column c = 16r+c, 2-cycle gaps.
  - Line 0 gives `vect_o`={0,0,c}.
  - Line 1 gives {0,c,16+c}.
  - Line 2 gives {c,16+c,32+c}, listed as `vect_o[2]`,`[1]`,`[0]`.
  - `dv_o` goes high 1 cycle after `dv_i`.
- Steady state: a 4th line of values 48+c gives {16+c,32+c,48+c}, proving the oldest row is discarded.
- Frame restart:
  - Stimulus: `vs_i` pulse after 3 full lines, then a line of values 0xA0+c.
  - Required: `vect_o`={0,0,0xA0+c}.
- Overflow:
  - Stimulus: `LINE_MAX`=8 build, 10-pixel line.
  - Required: `ovf_o` rises on pixel 8 and stays set until the next `vs_i` edge.
  - Required: the next line's `vect_o[1]` shows columns 0..7 only.
- Async reset:
  - Stimulus: `rst` asserted mid-line between clock edges.
  - Required: all outputs are 0 immediately, without waiting for a clock edge.
  - Required: the first post-reset line outputs {0,0,px}.
- Sync alignment: `hs_i`/`vs_i` toggles with `dv_i`=0 appear on `hs_o`/`vs_o` exactly 1 cycle later, and `vect_o` does not change.
